// File: rtl/booth_mac_accum.sv
// Accumulates LEN signed products into one dot-product result (optional saturation, sticky overflow).
// Result appears 1 cycle after the LEN-th transfer; prod_ready_o drops while a result waits for acc_ready_i.
module booth_mac_accum #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN    = 4,
    parameter int SAT    = 1,
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [PROD_W-1:0] prod_i,
    input  logic                     prod_valid_i,
    output logic                     prod_ready_o,
    input  logic                     clear_i,
    output logic signed [ACC_W-1:0]  acc_o,
    output logic                     acc_valid_o,
    input  logic                     acc_ready_i,
    output logic                     ovf_o,
    output logic [CNT_W-1:0]         count_o
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                   state, state_nxt;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         cnt;
    logic                     ovf_sticky;

    logic                     xfer;
    logic                     last;
    logic signed [ACC_W-1:0]  sum;
    logic                     ovf_now;
    logic signed [ACC_W-1:0]  acc_nxt;

    assign prod_ready_o = (state == ACCUM);
    assign xfer         = prod_valid_i && prod_ready_o;
    assign last         = (cnt == CNT_W'(LEN - 1));
    assign count_o      = cnt;

    // Only the ACC_W-bit sum sign is needed: overflow iff like-signed operands give an opposite-signed sum.
    assign sum     = acc + ACC_W'(prod_i);
    assign ovf_now = (acc[ACC_W-1] == prod_i[PROD_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

    always_comb begin
        acc_nxt = sum;
        if (ovf_now && (SAT != 0)) begin
            acc_nxt = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: if (xfer && !clear_i && last) state_nxt = HOLD;
            HOLD:  if (acc_ready_i) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            cnt         <= '0;
            ovf_sticky  <= 1'b0;
            acc_o       <= '0;
            acc_valid_o <= 1'b0;
            ovf_o       <= 1'b0;
        end else if (state == ACCUM) begin
            // A clear coinciding with a transfer swallows that product.
            if (clear_i) begin
                acc        <= '0;
                cnt        <= '0;
                ovf_sticky <= 1'b0;
            end else if (xfer) begin
                if (last) begin
                    acc_o       <= acc_nxt;
                    ovf_o       <= ovf_sticky | ovf_now;
                    acc_valid_o <= 1'b1;
                    acc         <= '0;
                    cnt         <= '0;
                    ovf_sticky  <= 1'b0;
                end else begin
                    acc        <= acc_nxt;
                    cnt        <= cnt + CNT_W'(1);
                    ovf_sticky <= ovf_sticky | ovf_now;
                end
            end
        end else if (acc_ready_i) begin
            acc_valid_o <= 1'b0;
            ovf_o       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_booth_mac_accum.sv
// Directed checks of booth_mac_accum in default, 16-bit saturate/wrap and LEN=1 configurations.
module tb_booth_mac_accum;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Default configuration: LEN=4, ACC_W=24, SAT=1
    logic signed [15:0] m_prod = '0;
    logic               m_valid = 1'b0, m_clear = 1'b0, m_ready = 1'b0;
    logic               m_prdy, m_avld, m_ovf;
    logic signed [23:0] m_acc;
    logic [2:0]         m_cnt;

    booth_mac_accum u_dut (
        .clk(clk), .rst(rst), .prod_i(m_prod), .prod_valid_i(m_valid), .prod_ready_o(m_prdy),
        .clear_i(m_clear), .acc_o(m_acc), .acc_valid_o(m_avld), .acc_ready_i(m_ready),
        .ovf_o(m_ovf), .count_o(m_cnt)
    );

    // 16-bit accumulators sharing one stimulus: saturating and wrapping
    logic signed [15:0] o_prod = '0;
    logic               o_valid = 1'b0, o_clear = 1'b0, o_ready = 1'b0;
    logic               s_prdy, s_avld, s_ovf, w_prdy, w_avld, w_ovf;
    logic signed [15:0] s_acc, w_acc;
    logic [2:0]         s_cnt, w_cnt;

    booth_mac_accum #(.ACC_W(16), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .prod_i(o_prod), .prod_valid_i(o_valid), .prod_ready_o(s_prdy),
        .clear_i(o_clear), .acc_o(s_acc), .acc_valid_o(s_avld), .acc_ready_i(o_ready),
        .ovf_o(s_ovf), .count_o(s_cnt)
    );

    booth_mac_accum #(.ACC_W(16), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .prod_i(o_prod), .prod_valid_i(o_valid), .prod_ready_o(w_prdy),
        .clear_i(o_clear), .acc_o(w_acc), .acc_valid_o(w_avld), .acc_ready_i(o_ready),
        .ovf_o(w_ovf), .count_o(w_cnt)
    );

    // LEN=1 pass-through configuration
    logic signed [15:0] l_prod = '0;
    logic               l_valid = 1'b0, l_ready = 1'b0;
    logic               l_prdy, l_avld, l_ovf;
    logic signed [23:0] l_acc;
    logic [0:0]         l_cnt;

    booth_mac_accum #(.LEN(1)) u_len1 (
        .clk(clk), .rst(rst), .prod_i(l_prod), .prod_valid_i(l_valid), .prod_ready_o(l_prdy),
        .clear_i(1'b0), .acc_o(l_acc), .acc_valid_o(l_avld), .acc_ready_i(l_ready),
        .ovf_o(l_ovf), .count_o(l_cnt)
    );

    task automatic m_push(input logic signed [15:0] p, input logic clr);
        m_prod = p; m_valid = 1'b1; m_clear = clr;
        @(posedge clk); #1;
        m_valid = 1'b0; m_clear = 1'b0;
    endtask

    task automatic m_drain();
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
    endtask

    task automatic o_push(input logic signed [15:0] p);
        o_prod = p; o_valid = 1'b1;
        @(posedge clk); #1;
        o_valid = 1'b0;
    endtask

    task automatic o_drain();
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0;
    endtask

    logic signed [15:0] q[$];
    logic signed [15:0] exp_p;
    int sent, got;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", m_avld, 0);
        check("rst_acc", m_acc, 0);
        check("rst_ovf", m_ovf, 0);
        check("rst_count", m_cnt, 0);
        check("rst_ready", m_prdy, 1);
        rst = 1'b0;

        // Basic group with result held, then stall with valid kept high
        m_push(100, 0);
        check("t1_count1", m_cnt, 1);
        m_push(-50, 0); m_push(7, 0); m_push(-1, 0);
        check("t1_valid", m_avld, 1);
        check("t1_acc", m_acc, 56);
        check("t1_ovf", m_ovf, 0);
        check("t1_ready", m_prdy, 0);
        check("t1_count", m_cnt, 0);

        m_prod = 3; m_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t2_hold_acc", m_acc, 56);
            check("t2_hold_valid", m_avld, 1);
            check("t2_hold_cnt", m_cnt, 0);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check("t2_release_valid", m_avld, 0);
        check("t2_release_ready", m_prdy, 1);
        check("t2_release_acc", m_acc, 56);
        repeat (3) @(posedge clk);
        #1;
        check("t2_count3", m_cnt, 3);
        @(posedge clk); #1;
        m_valid = 1'b0;
        check("t2_acc", m_acc, 12);
        check("t2_valid", m_avld, 1);
        m_drain();
        check("t2_drained", m_avld, 0);

        // Clear coinciding with a transfer discards the product
        m_push(10, 0);
        check("t3_count1", m_cnt, 1);
        m_push(20, 0);
        check("t3_count2", m_cnt, 2);
        m_push(30, 1);
        check("t3_count_clr", m_cnt, 0);
        check("t3_no_result", m_avld, 0);
        m_push(1, 0); m_push(2, 0); m_push(3, 0); m_push(4, 0);
        check("t3_acc", m_acc, 10);
        check("t3_valid", m_avld, 1);
        check("t3_ovf", m_ovf, 0);
        m_clear = 1'b1;
        @(posedge clk); #1;
        m_clear = 1'b0;
        check("t3_clear_in_hold", m_avld, 1);
        m_drain();

        // Reset while holding a result
        m_push(100, 0); m_push(-50, 0); m_push(7, 0); m_push(-1, 0);
        check("t4_pre_acc", m_acc, 56);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t4_valid", m_avld, 0);
        check("t4_acc", m_acc, 0);
        check("t4_ovf", m_ovf, 0);
        check("t4_count", m_cnt, 0);
        check("t4_ready", m_prdy, 1);
        m_push(1, 0); m_push(1, 0); m_push(1, 0); m_push(1, 0);
        check("t4_acc4", m_acc, 4);
        m_drain();

        // Overflow: saturate versus wrap
        for (int i = 0; i < 4; i++) o_push(16384);
        check("ov_pos_sat_acc", s_acc, 32767);
        check("ov_pos_sat_ovf", s_ovf, 1);
        check("ov_pos_wrap_acc", w_acc, 0);
        check("ov_pos_wrap_ovf", w_ovf, 1);
        o_drain();
        check("ov_drain_ovf", s_ovf, 0);
        for (int i = 0; i < 4; i++) o_push(-16384);
        check("ov_neg_sat_acc", s_acc, -32768);
        check("ov_neg_sat_ovf", s_ovf, 1);
        check("ov_neg_wrap_acc", w_acc, 0);
        check("ov_neg_wrap_ovf", w_ovf, 1);
        o_drain();
        for (int i = 0; i < 4; i++) o_push(1);
        check("ov_sticky_sat_acc", s_acc, 4);
        check("ov_sticky_sat_ovf", s_ovf, 0);
        check("ov_sticky_wrap_ovf", w_ovf, 0);
        o_drain();

        // LEN=1 random stream with stalls, scoreboarded
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 20000 && got < 2000; cyc++) begin
            @(posedge clk); #1;
            l_valid = (sent < 2000) && ($urandom_range(0, 3) != 0);
            l_prod  = l_valid ? 16'($urandom) : 16'hxxxx;
            l_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (l_avld && l_ready) begin
                if (q.size() == 0) begin
                    check("len1_spurious", 1, 0);
                end else begin
                    exp_p = q.pop_front();
                    check("len1_acc", l_acc, exp_p);
                    check("len1_ovf", l_ovf, 0);
                end
                got++;
            end
            if (l_valid && l_prdy) begin
                q.push_back(l_prod);
                sent++;
            end
        end
        l_valid = 1'b0;
        l_ready = 1'b0;
        check("len1_results", got, 2000);
        check("len1_leftover", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
